fb_writer: RTL

FB_WRITER -- requirements
Module: fb_writer

---
 rtl/fb_writer_if.sv | 25 ++
 rtl/fb_writer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/fb_writer_if.sv
// fb_writer_if: request, fill-control and RAM-write signals of the framebuffer writer.
// The master side drives requests and fill commands; the slave side is the writer.
interface fb_writer_if;
    logic       req_valid;
    logic       req_ready;
    logic [8:0] req_addr;
    logic [7:0] req_data;
    logic       clear;
    logic [7:0] clear_data;
    logic       busy;
    logic       done;
    logic       wr_en;
    logic [8:0] wr_addr;
    logic [7:0] wr_data;

    modport master (
        output req_valid, req_addr, req_data, clear, clear_data,
        input  req_ready, busy, done, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  req_valid, req_addr, req_data, clear, clear_data,
        output req_ready, busy, done, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/fb_writer.sv
// fb_writer: single-byte writes into a 512x8 framebuffer RAM, plus an optional
// full-buffer fill enabled by defining FB_WRITER_CLEAR_EN.
module fb_writer (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic [8:0] req_addr_i,
    input  logic [7:0] req_data_i,
    input  logic       clear_i,
    input  logic [7:0] clear_data_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       wr_en_o,
    output logic [8:0] wr_addr_o,
    output logic [7:0] wr_data_o
);

    logic       handshake_s;
    logic       wr_en_r;
    logic       wr_en_s;
    logic [8:0] wr_addr_r;
    logic [8:0] wr_addr_s;
    logic [7:0] wr_data_r;
    logic [7:0] wr_data_s;

    assign handshake_s = req_valid_i & req_ready_o;

    // RAM write port registers; address and data hold between writes
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_en_r   <= 1'b0;
            wr_addr_r <= 9'd0;
            wr_data_r <= 8'd0;
        end else begin
            wr_en_r   <= wr_en_s;
            wr_addr_r <= wr_addr_s;
            wr_data_r <= wr_data_s;
        end
    end

    assign wr_en_o   = wr_en_r;
    assign wr_addr_o = wr_addr_r;
    assign wr_data_o = wr_data_r;

`ifdef FB_WRITER_CLEAR_EN

    localparam logic [8:0] LAST_ADDR = 9'd511;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t     state_r;
    state_t     state_s;
    logic [8:0] cnt_r;
    logic [8:0] cnt_s;
    logic [7:0] fill_r;
    logic [7:0] fill_s;
    logic       done_r;
    logic       done_s;

    // fill FSM state, counter, captured fill byte and done pulse
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r <= IDLE;
            cnt_r   <= 9'd0;
            fill_r  <= 8'd0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            fill_r  <= fill_s;
            done_r  <= done_s;
        end
    end

    // next state and write selection; a request accepted alongside clear_i
    // is written first, so the fill that follows overwrites it
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        fill_s    = fill_r;
        done_s    = 1'b0;
        wr_en_s   = 1'b0;
        wr_addr_s = wr_addr_r;
        wr_data_s = wr_data_r;
        case (state_r)
            IDLE: begin
                if (handshake_s) begin
                    wr_en_s   = 1'b1;
                    wr_addr_s = req_addr_i;
                    wr_data_s = req_data_i;
                end else begin
                    wr_en_s   = 1'b0;
                end
                if (clear_i) begin
                    state_s = CLEAR;
                    fill_s  = clear_data_i;
                    cnt_s   = 9'd0;
                end else begin
                    state_s = IDLE;
                end
            end
            CLEAR: begin
                wr_en_s   = 1'b1;
                wr_addr_s = cnt_r;
                wr_data_s = fill_r;
                // the counter parks at the last address rather than wrapping
                if (cnt_r == LAST_ADDR) begin
                    done_s  = 1'b1;
                    state_s = IDLE;
                end else begin
                    cnt_s   = cnt_r + 9'd1;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    assign req_ready_o = (state_r == IDLE);
    assign busy_o      = (state_r == CLEAR);
    assign done_o      = done_r;

`else

    logic unused_clear_s;

    assign unused_clear_s = ^{clear_i, clear_data_i};

    // plain request path: one write per accepted request
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = wr_addr_r;
        wr_data_s = wr_data_r;
        if (handshake_s) begin
            wr_en_s   = 1'b1;
            wr_addr_s = req_addr_i;
            wr_data_s = req_data_i;
        end else begin
            wr_en_s   = 1'b0;
        end
    end

    assign req_ready_o = 1'b1;
    assign busy_o      = 1'b0;
    assign done_o      = 1'b0;

`endif

endmodule
